// File: rtl/stack_xfer_if.sv
// Handshake/bus bundle for stack_xfer_unit: start request, register-file ports, PC/SP strobes, data-memory port.
// The fault signal exists only when STACK_ALIGN_CHECK_EN is defined.
interface stack_xfer_if #(
  parameter int ADDR_W = 32
);
  logic              start;
  logic              op_pop;
  logic [7:0]        reg_list;
  logic              reg_extra;
  logic [ADDR_W-1:0] sp_in;
  logic              busy;
  logic              done;
  logic [3:0]        rf_raddr;
  logic [31:0]       rf_rdata;
  logic              rf_ld_rd;
  logic [3:0]        rf_waddr;
  logic [31:0]       rf_wdata;
  logic              pc_ld;
  logic [31:0]       pc_wdata;
  logic              sp_ld;
  logic [ADDR_W-1:0] sp_wdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
`ifdef STACK_ALIGN_CHECK_EN
  logic              fault;
`endif

  modport master (
    input  start, op_pop, reg_list, reg_extra, sp_in, rf_rdata, mem_ack, mem_rdata,
    output busy, done, rf_raddr, rf_ld_rd, rf_waddr, rf_wdata, pc_ld, pc_wdata,
    output sp_ld, sp_wdata, mem_req, mem_we, mem_addr, mem_wdata
`ifdef STACK_ALIGN_CHECK_EN
    , output fault
`endif
  );

  modport slave (
    output start, op_pop, reg_list, reg_extra, sp_in, rf_rdata, mem_ack, mem_rdata,
    input  busy, done, rf_raddr, rf_ld_rd, rf_waddr, rf_wdata, pc_ld, pc_wdata,
    input  sp_ld, sp_wdata, mem_req, mem_we, mem_addr, mem_wdata
`ifdef STACK_ALIGN_CHECK_EN
    , input fault
`endif
  );
endinterface

// File: rtl/stack_xfer_unit.sv
// Thumb PUSH/POP register-list sequencer between the core register file and the data-memory port.
// Define STACK_ALIGN_CHECK_EN to add the misaligned-SP fault output.
module stack_xfer_unit #(
  parameter int                ADDR_W = 32,
  parameter logic [ADDR_W-1:0] SP_RST = '0
) (
  input logic          clk,
  input logic          rst,
  stack_xfer_if.master bus
);
  // state | meaning
  // IDLE  | waiting for start
  // XFER  | one memory beat per handshake, lowest register first
  // DONE  | done pulse, SP update
  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

  function automatic logic [3:0] f_popcnt(input logic [8:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 9; i++) c = c + 4'(v[i]);
    return c;
  endfunction

  function automatic logic [3:0] f_first(input logic [8:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 8; i >= 0; i--) if (v[i]) idx = 4'(i);
    return idx;
  endfunction

  // Slot 8 of the pending mask is the extra register: LR for PUSH, PC for POP.
  function automatic logic [3:0] f_regnum(input logic [3:0] idx, input logic pop);
    if (idx == 4'd8) return pop ? 4'd15 : 4'd14;
    return idx;
  endfunction

  state_t            r_state;
  logic              r_pop;
  logic [8:0]        r_pend;
  logic [3:0]        r_n;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_addr;
  logic              r_busy;
  logic              r_done;
  logic [3:0]        r_rf_raddr;
  logic              r_rf_ld_rd;
  logic [3:0]        r_rf_waddr;
  logic [31:0]       r_rf_wdata;
  logic              r_pc_ld;
  logic [31:0]       r_pc_wdata;
  logic              r_sp_ld;
  logic [ADDR_W-1:0] r_sp_wdata;
  logic              r_mem_req;
  logic              r_mem_we;

  logic [8:0]        w_start_pend;
  logic [3:0]        w_n;
  logic [ADDR_W-1:0] w_sp_al;
  logic [ADDR_W-1:0] w_push_base;
  logic [3:0]        w_cur;
  logic [8:0]        w_next_pend;
  logic              w_skip;

  assign w_start_pend = {bus.reg_extra, bus.reg_list};
  assign w_n          = f_popcnt(w_start_pend);
  assign w_sp_al      = bus.sp_in & ~ADDR_W'(3);
  assign w_push_base  = w_sp_al - ADDR_W'({w_n, 2'b00});
  assign w_cur        = f_first(r_pend);
  assign w_next_pend  = r_pend & ~(9'd1 << w_cur);

`ifdef STACK_ALIGN_CHECK_EN
  logic r_fault;
  logic w_misal;
  assign w_misal   = |bus.sp_in[1:0];
  assign w_skip    = (w_n == 4'd0) || w_misal;
  assign bus.fault = r_fault;
`else
  assign w_skip = (w_n == 4'd0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pop      <= 1'b0;
      r_pend     <= '0;
      r_n        <= '0;
      r_base     <= '0;
      r_addr     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rf_raddr <= '0;
      r_rf_ld_rd <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
      r_pc_ld    <= 1'b0;
      r_pc_wdata <= '0;
      r_sp_ld    <= 1'b0;
      r_sp_wdata <= SP_RST;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
`ifdef STACK_ALIGN_CHECK_EN
      r_fault    <= 1'b0;
`endif
    end else begin
      r_done     <= 1'b0;
      r_rf_ld_rd <= 1'b0;
      r_pc_ld    <= 1'b0;
      r_sp_ld    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_pop  <= bus.op_pop;
            r_n    <= w_n;
            r_pend <= w_start_pend;
            r_base <= bus.op_pop ? w_sp_al : w_push_base;
            r_busy <= 1'b1;
`ifdef STACK_ALIGN_CHECK_EN
            r_fault <= w_misal && (w_n != 4'd0);
`endif
            if (w_skip) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= S_XFER;
              r_mem_req  <= 1'b1;
              r_mem_we   <= ~bus.op_pop;
              r_addr     <= bus.op_pop ? w_sp_al : w_push_base;
              r_rf_raddr <= bus.op_pop ? 4'd0 : f_regnum(f_first(w_start_pend), 1'b0);
            end
          end
        end
        S_XFER: begin
          if (bus.mem_ack) begin
            r_pend <= w_next_pend;
            r_addr <= r_addr + ADDR_W'(4);
            if (r_pop) begin
              if (w_cur == 4'd8) begin
                r_pc_ld    <= 1'b1;
                r_pc_wdata <= bus.mem_rdata & ~32'h1;
              end else begin
                r_rf_ld_rd <= 1'b1;
                r_rf_waddr <= w_cur;
                r_rf_wdata <= bus.mem_rdata;
              end
            end
            if (w_next_pend == 9'd0) begin
              r_state    <= S_DONE;
              r_mem_req  <= 1'b0;
              r_mem_we   <= 1'b0;
              r_done     <= 1'b1;
              r_sp_ld    <= 1'b1;
              r_sp_wdata <= r_pop ? r_base + ADDR_W'({r_n, 2'b00}) : r_base;
              r_rf_raddr <= 4'd0;
            end else begin
              r_rf_raddr <= r_pop ? 4'd0 : f_regnum(f_first(w_next_pend), 1'b0);
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.rf_raddr  = r_rf_raddr;
  assign bus.rf_ld_rd  = r_rf_ld_rd;
  assign bus.rf_waddr  = r_rf_waddr;
  assign bus.rf_wdata  = r_rf_wdata;
  assign bus.pc_ld     = r_pc_ld;
  assign bus.pc_wdata  = r_pc_wdata;
  assign bus.sp_ld     = r_sp_ld;
  assign bus.sp_wdata  = r_sp_wdata;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_addr;
  // Write data follows the register-file read port directly.
  assign bus.mem_wdata = (r_mem_req && r_mem_we) ? bus.rf_rdata : 32'h0;
endmodule

// File: tb/tb_stack_xfer_unit.sv
// Directed bench for stack_xfer_unit: table of PUSH/POP transfers plus reset and busy corner cases.
// Define STACK_ALIGN_CHECK_EN to also check the misaligned-SP fault path.
module tb_stack_xfer_unit;
  localparam logic [31:0] SP_RST = 32'h2000_0400;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  stack_xfer_if #(.ADDR_W(32)) bus();
  stack_xfer_unit #(.ADDR_W(32), .SP_RST(SP_RST)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    string       name;
    bit          pop;
    logic [7:0]  list;
    bit          extra;
    logic [31:0] sp;
    int          dly;
    int          beats;
    logic [31:0] addr0;
    logic [35:0] regs;
    bit          sp_ld;
    logic [31:0] sp_exp;
    int          lat;
    bit          fault;
    bit          extra_start;
  } vec_t;

  function automatic logic [31:0] rf_val(input logic [3:0] r);
    if (r == 4'd14) return 32'hFFFF_FFFF;
    return 32'h100 + 32'(r);
  endfunction

  assign bus.rf_rdata = rf_val(bus.rf_raddr);

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int dly = 0;
  logic [31:0] pop_data [9];

  int start_cyc, done_cyc, done_cnt, strobe_cyc, n_beats, n_rfw, pc_cnt, sp_cnt;
  int req_cyc, unstable, busy_err, wait_cnt;
  bit done_seen, prev_done, prev_hold, h_we;
  logic [31:0] h_addr, h_wdata, pc_val, sp_val;
  logic [31:0] b_addr [16];
  logic [31:0] b_wdata [16];
  bit          b_we [16];
  logic [3:0]  rfw_reg [16];
  logic [31:0] rfw_dat [16];

  always @(posedge clk) cyc++;

  // Memory responder and strobe monitor; acks after dly wait cycles.
  always @(negedge clk) begin
    if (rst) begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'h0;
      wait_cnt      = 0;
      prev_hold     = 1'b0;
      prev_done     = 1'b0;
    end else begin
      if (bus.start && !bus.busy) start_cyc = cyc;
      if (prev_done && bus.busy) busy_err++;
      prev_done = bus.done;
      if (bus.done) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
        done_cnt++;
        if (!bus.busy) busy_err++;
      end
      if (bus.rf_ld_rd) begin
        if (n_rfw < 16) begin
          rfw_reg[n_rfw] = bus.rf_waddr;
          rfw_dat[n_rfw] = bus.rf_wdata;
        end
        n_rfw++;
        strobe_cyc = cyc;
      end
      if (bus.pc_ld) begin
        pc_cnt++;
        pc_val     = bus.pc_wdata;
        strobe_cyc = cyc;
      end
      if (bus.sp_ld) begin
        sp_cnt++;
        sp_val = bus.sp_wdata;
      end
      if (bus.mem_req) begin
        req_cyc++;
        if (prev_hold && (bus.mem_addr !== h_addr || bus.mem_we !== h_we || bus.mem_wdata !== h_wdata))
          unstable++;
        h_addr  = bus.mem_addr;
        h_we    = bus.mem_we;
        h_wdata = bus.mem_wdata;
        if (wait_cnt >= dly) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = (n_beats < 9) ? pop_data[n_beats] : 32'hDEAD_BEEF;
          if (n_beats < 16) begin
            b_addr[n_beats]  = bus.mem_addr;
            b_we[n_beats]    = bus.mem_we;
            b_wdata[n_beats] = bus.mem_wdata;
          end
          n_beats++;
          wait_cnt  = 0;
          prev_hold = 1'b0;
        end else begin
          bus.mem_ack = 1'b0;
          wait_cnt++;
          prev_hold = 1'b1;
        end
      end else begin
        bus.mem_ack = 1'b0;
        wait_cnt    = 0;
        prev_hold   = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic clear_logs();
    done_seen = 1'b0; done_cnt = 0; n_beats = 0; n_rfw = 0; pc_cnt = 0; sp_cnt = 0;
    req_cyc = 0; unstable = 0; busy_err = 0; strobe_cyc = -1; done_cyc = -1;
    pc_val = 32'h0; sp_val = 32'h0;
  endtask

  task automatic run_vec(input vec_t v);
    int t;
    int j;
    logic [3:0] r;
    clear_logs();
    dly = v.dly;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op_pop = v.pop; bus.reg_list = v.list;
    bus.reg_extra = v.extra; bus.sp_in = v.sp;
    @(posedge clk); #1;
    bus.start = 1'b0;
    t = 0;
    while (!done_seen && t < 300) begin
      @(posedge clk); #1;
      t++;
      if (v.extra_start && t == 2) begin
        bus.start = 1'b1; bus.op_pop = 1'b0; bus.reg_list = 8'hFF;
        bus.reg_extra = 1'b1; bus.sp_in = 32'h500;
      end else begin
        bus.start = 1'b0;
      end
    end
    @(negedge clk); #1;
    chk({v.name, ".done_seen"}, 32'(done_seen), 32'd1);
    chk({v.name, ".latency"}, 32'(done_cyc - start_cyc), 32'(v.lat));
    chk({v.name, ".done_count"}, 32'(done_cnt), 32'd1);
    chk({v.name, ".busy_window"}, 32'(busy_err), 32'd0);
    chk({v.name, ".beats"}, 32'(n_beats), 32'(v.beats));
    chk({v.name, ".req_cycles"}, 32'(req_cyc), 32'(v.beats * (v.dly + 1)));
    chk({v.name, ".stable"}, 32'(unstable), 32'd0);
    j = 0;
    for (int k = 0; k < v.beats && k < 16; k++) begin
      r = v.regs[4*k +: 4];
      chk($sformatf("%s.addr%0d", v.name, k), b_addr[k], v.addr0 + 32'(4 * k));
      chk($sformatf("%s.we%0d", v.name, k), 32'(b_we[k]), 32'(!v.pop));
      if (!v.pop) begin
        chk($sformatf("%s.wdata%0d", v.name, k), b_wdata[k], rf_val(r));
      end else if (r == 4'd15) begin
        chk($sformatf("%s.pc%0d", v.name, k), pc_val, pop_data[k] & ~32'h1);
      end else begin
        chk($sformatf("%s.rfreg%0d", v.name, k), 32'(rfw_reg[j]), 32'(r));
        chk($sformatf("%s.rfdat%0d", v.name, k), rfw_dat[j], pop_data[k]);
        j++;
      end
    end
    if (v.pop) begin
      chk({v.name, ".rf_writes"}, 32'(n_rfw), 32'(j));
      chk({v.name, ".pc_loads"}, 32'(pc_cnt), 32'(v.extra && v.beats > 0));
      if (v.beats > 0) chk({v.name, ".last_strobe"}, 32'(strobe_cyc), 32'(done_cyc));
    end else begin
      chk({v.name, ".rf_writes"}, 32'(n_rfw), 32'd0);
      chk({v.name, ".pc_loads"}, 32'(pc_cnt), 32'd0);
    end
    chk({v.name, ".sp_loads"}, 32'(sp_cnt), 32'(v.sp_ld));
    if (v.sp_ld) chk({v.name, ".sp_wdata"}, sp_val, v.sp_exp);
`ifdef STACK_ALIGN_CHECK_EN
    chk({v.name, ".fault"}, 32'(bus.fault), 32'(v.fault));
`endif
  endtask

  vec_t vecs [8];
  vec_t post;

  initial begin
    int t;
    bus.start = 1'b0; bus.op_pop = 1'b0; bus.reg_list = 8'h0; bus.reg_extra = 1'b0; bus.sp_in = 32'h0;
    pop_data = '{32'hA, 32'hB, 32'h201, 32'hD, 32'hE, 32'hF, 32'h10, 32'h11, 32'h13};
    //            name             pop list   ext sp              dly beats addr0          regs            spld sp_exp          lat flt xs
    vecs[0] = '{"push_r1_r2_lr",   0, 8'h06, 1, 32'h0000_0100, 0, 3, 32'h0000_00F4, 36'h0_0000_0E21, 1, 32'h0000_00F4, 4,  0, 0};
    vecs[1] = '{"pop_r0_r3_pc",    1, 8'h09, 1, 32'h0000_00F4, 0, 3, 32'h0000_00F4, 36'h0_0000_0F30, 1, 32'h0000_0100, 4,  0, 0};
    vecs[2] = '{"push_r4_wait3",   0, 8'h10, 0, 32'h0000_0100, 3, 1, 32'h0000_00FC, 36'h0_0000_0004, 1, 32'h0000_00FC, 5,  0, 0};
    vecs[3] = '{"empty_list",      0, 8'h00, 0, 32'h0000_0200, 0, 0, 32'h0000_0000, 36'h0,           0, 32'h0000_0000, 1,  0, 0};
    vecs[4] = '{"pop_all_wait1",   1, 8'hFF, 1, 32'h0000_1000, 1, 9, 32'h0000_1000, 36'hF_7654_3210, 1, 32'h0000_1024, 19, 0, 1};
    vecs[5] = '{"push_wrap",       0, 8'h81, 1, 32'h0000_0004, 0, 3, 32'hFFFF_FFF8, 36'h0_0000_0E70, 1, 32'hFFFF_FFF8, 4,  0, 0};
`ifdef STACK_ALIGN_CHECK_EN
    vecs[6] = '{"push_misaligned", 0, 8'h01, 0, 32'h0000_0102, 0, 0, 32'h0000_0000, 36'h0,           0, 32'h0000_0000, 1,  1, 0};
`else
    vecs[6] = '{"push_misaligned", 0, 8'h01, 0, 32'h0000_0102, 0, 1, 32'h0000_00FC, 36'h0_0000_0000, 1, 32'h0000_00FC, 2,  0, 0};
`endif
    vecs[7] = '{"pop_pc_only",     1, 8'h00, 1, 32'h0000_0080, 0, 1, 32'h0000_0080, 36'h0_0000_000F, 1, 32'h0000_0084, 2,  0, 0};
    post    = '{"post_rst_push",   0, 8'h04, 0, 32'h0000_0400, 0, 1, 32'h0000_03FC, 36'h0_0000_0002, 1, 32'h0000_03FC, 2,  0, 0};

    #1 rst = 1'b1;
    #2;
    chk("reset.busy", 32'(bus.busy), 32'd0);
    chk("reset.done", 32'(bus.done), 32'd0);
    chk("reset.mem_req", 32'(bus.mem_req), 32'd0);
    chk("reset.mem_addr", bus.mem_addr, 32'd0);
    chk("reset.strobes", {29'd0, bus.rf_ld_rd, bus.pc_ld, bus.sp_ld}, 32'd0);
    chk("reset.sp_wdata", bus.sp_wdata, SP_RST);
`ifdef STACK_ALIGN_CHECK_EN
    chk("reset.fault", 32'(bus.fault), 32'd0);
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // POP of four registers interrupted by reset after the second ack.
    clear_logs();
    dly = 0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op_pop = 1'b1; bus.reg_list = 8'h0F; bus.reg_extra = 1'b0; bus.sp_in = 32'h300;
    @(posedge clk); #1;
    bus.start = 1'b0;
    t = 0;
    while (n_beats < 2 && t < 50) begin
      @(negedge clk); #1;
      t++;
    end
    chk("rst_mid.acks_before", 32'(n_beats), 32'd2);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_mid.mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mid.busy", 32'(bus.busy), 32'd0);
    chk("rst_mid.rf_ld_rd", 32'(bus.rf_ld_rd), 32'd0);
    chk("rst_mid.sp_wdata", bus.sp_wdata, SP_RST);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_mid.idle_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mid.sp_loads", 32'(sp_cnt), 32'd0);
    chk("rst_mid.done_count", 32'(done_cnt), 32'd0);
    chk("rst_mid.rf_writes", 32'(n_rfw), 32'd1);
    chk("rst_mid.rf_r0", rfw_dat[0], 32'hA);

    run_vec(post);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
